hazard_scheduler: RTL and testbench
===================================

Name: hazard_scheduler

Overview:
- Pipeline control block between decode and execute.
- Tracks in-flight destination registers for the EX and MEM stages and issues decoded instructions into execute.
- Generates per-operand forwarding selects, load-use stalls, branch flushes and halt drain sequencing.
- Drives the hazard/forward inputs of the execute stage and the hold/squash controls of fetch/decode.

Parameters:
REG_AW, 4, register address width (16 architectural registers)
FLUSH_CYCLES, 2, cycles flush is asserted per taken branch (minimum 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  decode holds an instruction
id_src1  in  REG_AW  operand 1 register
id_src1_used  in  1  operand 1 reads a register
id_src2  in  REG_AW  operand 2 register
id_src2_used  in  1  operand 2 reads a register
id_dst  in  REG_AW  destination register
id_reg_write  in  1  instruction writes id_dst
id_is_load  in  1  result comes from memory read
id_is_halt  in  1  halt instruction
ex_do_branch  in  1  execute reports taken branch this cycle
issue  out  1  decode instruction enters EX at this edge (combinational)
stall  out  1  hold fetch/decode (combinational)
flush  out  1  squash fetch/decode contents (combinational)
fwd1_sel  out  2  operand 1 source for instruction now in EX: 0 regfile, 1 EX result, 2 MEM value (registered)
fwd2_sel  out  2  same for operand 2 (registered)
halted  out  1  pipeline drained after halt (registered)

Behaviour:
Reset:
- state=RUN; EX/MEM slots invalid; fwd1_sel=fwd2_sel=0; halted=0; flush counter=0.
- Reset asserted mid-operation aborts any FLUSH/DRAIN immediately.

Scoreboard slots:
- EX slot = {valid, dst, wr, load}; MEM slot = {valid, dst, wr}.
- Every edge: MEM <= EX; EX <= decode fields if issue, else bubble (valid=0).
- A slot matches source s when valid && wr && dst==s && the operand's *_used bit is set.

Operand source selection (per operand, evaluated on decode fields):
- match EX slot && !EX.load -> 1
- else match MEM slot -> 2
- else -> 0
- EX match has priority over MEM match (younger producer wins).
- fwdN_sel is registered on an issue edge. On a non-issue edge it clears to 0.

Load-use:
- load_use = id_valid && (either operand matches EX slot with EX.load=1).
- Inserts exactly one bubble. The next cycle the load sits in MEM and the operand forwards with select 2.

States:
- RUN:
  - issue = id_valid && !load_use && !ex_do_branch.
  - stall = id_valid && load_use.
  - ex_do_branch -> FLUSH, with counter = FLUSH_CYCLES-1, or stay in RUN if FLUSH_CYCLES=1. The EX slot loads a bubble.
  - else issue && id_is_halt -> DRAIN.
- FLUSH:
  - flush=1, stall=1, issue=0.
  - Counter decrements each cycle; at 0 -> RUN.
  - ex_do_branch here reloads the counter.
- DRAIN:
  - stall=1, issue=0.
  - When EX and MEM slots are both invalid -> HALTED. This takes 2 cycles after halt issue.
  - A taken branch in DRAIN is impossible by construction and is ignored.
- HALTED:
  - halted=1, stall=1, issue=0 until rst.

Flush and priority:
- flush = ex_do_branch || state==FLUSH. Total flush length = FLUSH_CYCLES cycles including the branch cycle.
- Priority: rst > ex_do_branch > halt > load_use.
- A halt in decode during a taken branch is squashed and not issued.

Test Plan:
- Forward from EX: issue add r3<-..., then sub src1=r3 next cycle -> fwd1_sel=1, fwd2_sel=0, no stall.
- Forward from MEM: r5 written, one unrelated instruction, then reader of r5 on src2 -> fwd2_sel=2; r5 written in both EX and MEM -> fwd2_sel=1.
- Load-use: load r2 then consumer src1=r2 -> stall=1 for 1 cycle, issue=0, bubble in EX; next edge issues with fwd1_sel=2.
- Branch: ex_do_branch=1 with FLUSH_CYCLES=2 -> flush=1 for 2 cycles, issue=0 throughout, EX bubble; a halt in decode during that cycle is not issued, halted stays 0.
- Halt: issue halt with two older instructions in flight -> stall=1 immediately, halted=1 two cycles after halt issue, held; rst pulse -> halted=0, fwd sels 0, RUN.
- Async reset: assert rst between clock edges during FLUSH -> flush drops to 0 without waiting for a clock edge; slots invalid, state RUN.

Source files
------------

// File: rtl/hazard_scheduler.sv
// Decode-to-execute hazard control: in-flight destination tracking, operand
// forwarding selects, load-use stalls, branch flush and halt drain sequencing.
module hazard_scheduler #(
  parameter int unsigned REG_AW       = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic              id_src1_used,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src2_used,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_is_halt,
  input  logic              ex_do_branch,
  output logic              issue,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd1_sel,
  output logic [1:0]        fwd2_sel,
  output logic              halted
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               ex_valid, ex_wr, ex_load;
  logic [REG_AW-1:0]  ex_dst;
  logic               mem_valid, mem_wr;
  logic [REG_AW-1:0]  mem_dst;

  logic               m1_ex, m2_ex, m1_mem, m2_mem;
  logic               load_use;
  logic [1:0]         sel1, sel2;

  // Producer matches against the decode operands
  always_comb begin
    m1_ex    = ex_valid  && ex_wr  && (ex_dst  == id_src1) && id_src1_used;
    m2_ex    = ex_valid  && ex_wr  && (ex_dst  == id_src2) && id_src2_used;
    m1_mem   = mem_valid && mem_wr && (mem_dst == id_src1) && id_src1_used;
    m2_mem   = mem_valid && mem_wr && (mem_dst == id_src2) && id_src2_used;
    load_use = id_valid && ex_load && (m1_ex || m2_ex);
    sel1     = (m1_ex && !ex_load) ? 2'd1 : (m1_mem ? 2'd2 : 2'd0);
    sel2     = (m2_ex && !ex_load) ? 2'd1 : (m2_mem ? 2'd2 : 2'd0);
  end

  // Next state and combinational pipeline controls
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    issue     = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    case (state)
      S_RUN: begin
        stall = id_valid && load_use;
        if (ex_do_branch) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = S_FLUSH;
            cnt_nxt   = CNT_RELOAD;
          end
        end else begin
          issue = id_valid && !load_use;
          if (issue && id_is_halt) state_nxt = S_DRAIN;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        stall = 1'b1;
        if (ex_do_branch) begin
          cnt_nxt = CNT_RELOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        stall = 1'b1;
        // EX empties into MEM at this edge, so both slots are empty afterwards
        if (!ex_valid) state_nxt = S_HALTED;
      end
      S_HALTED: begin
        stall = 1'b1;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_RUN;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      halted <= (state_nxt == S_HALTED);
    end
  end

  // Scoreboard slots and registered forwarding selects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_load   <= 1'b0;
      ex_dst    <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_dst   <= '0;
      fwd1_sel  <= 2'd0;
      fwd2_sel  <= 2'd0;
    end else begin
      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_dst   <= ex_dst;
      ex_valid  <= issue;
      ex_wr     <= issue && id_reg_write;
      ex_load   <= issue && id_is_load;
      ex_dst    <= id_dst;
      fwd1_sel  <= issue ? sel1 : 2'd0;
      fwd2_sel  <= issue ? sel2 : 2'd0;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler: directed scenarios plus randomized traffic
// checked against a cycle-history reference model.
module tb_hazard_scheduler;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_src1 = '0, id_src2 = '0, id_dst = '0;
  logic       id_src1_used = 1'b0, id_src2_used = 1'b0;
  logic       id_reg_write = 1'b0, id_is_load = 1'b0, id_is_halt = 1'b0;
  logic       ex_do_branch = 1'b0;
  logic       issue, stall, flush, halted;
  logic [1:0] fwd1_sel, fwd2_sel;

  int n_cmp = 0;
  int n_err = 0;

  hazard_scheduler #(.REG_AW(4), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_is_halt(id_is_halt),
    .ex_do_branch(ex_do_branch),
    .issue(issue), .stall(stall), .flush(flush),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Drive one decode cycle at the falling edge, then settle for sampling
  task automatic put(input logic v, input logic [3:0] s1, input logic u1,
                     input logic [3:0] s2, input logic u2, input logic [3:0] d,
                     input logic w, input logic l, input logic hl, input logic b);
    @(negedge clk);
    id_valid = v; id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
    id_dst = d; id_reg_write = w; id_is_load = l; id_is_halt = hl; ex_do_branch = b;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    id_valid = 0; id_is_halt = 0; ex_do_branch = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (fwd1_sel !== 2'd0) begin n_err++; $display("FAIL reset.fwd1 got=%0d exp=0", fwd1_sel); end
    n_cmp++; if (fwd2_sel !== 2'd0) begin n_err++; $display("FAIL reset.fwd2 got=%0d exp=0", fwd2_sel); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset.halted got=%0b exp=0", halted); end
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset.flush got=%0b exp=0", flush); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset.stall got=%0b exp=0", stall); end
    rst = 1'b0;
  endtask

  task automatic test_fwd_ex();
    idle(2);
    put(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL fwd_ex.issue_add got=%0b exp=1", issue); end
    put(1, 3, 1, 7, 1, 4, 1, 0, 0, 0);
    n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL fwd_ex.issue_sub got=%0b exp=1", issue); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL fwd_ex.stall got=%0b exp=0", stall); end
    idle(1);
    n_cmp++; if (fwd1_sel !== 2'd1) begin n_err++; $display("FAIL fwd_ex.fwd1 got=%0d exp=1", fwd1_sel); end
    n_cmp++; if (fwd2_sel !== 2'd0) begin n_err++; $display("FAIL fwd_ex.fwd2 got=%0d exp=0", fwd2_sel); end
  endtask

  task automatic test_fwd_mem();
    idle(2);
    put(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    put(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    put(1, 0, 0, 5, 1, 6, 1, 0, 0, 0);
    idle(1);
    n_cmp++; if (fwd2_sel !== 2'd2) begin n_err++; $display("FAIL fwd_mem.fwd2 got=%0d exp=2", fwd2_sel); end
    n_cmp++; if (fwd1_sel !== 2'd0) begin n_err++; $display("FAIL fwd_mem.fwd1 got=%0d exp=0", fwd1_sel); end
    put(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    put(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    put(1, 0, 0, 5, 1, 6, 1, 0, 0, 0);
    idle(1);
    n_cmp++; if (fwd2_sel !== 2'd1) begin n_err++; $display("FAIL fwd_mem.younger_wins got=%0d exp=1", fwd2_sel); end
  endtask

  task automatic test_load_use();
    idle(2);
    put(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    put(1, 2, 1, 0, 0, 8, 1, 0, 0, 0);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL load_use.stall got=%0b exp=1", stall); end
    n_cmp++; if (issue !== 1'b0) begin n_err++; $display("FAIL load_use.issue got=%0b exp=0", issue); end
    put(1, 2, 1, 0, 0, 8, 1, 0, 0, 0);
    n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL load_use.reissue got=%0b exp=1", issue); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL load_use.stall_once got=%0b exp=0", stall); end
    n_cmp++; if (fwd1_sel !== 2'd0) begin n_err++; $display("FAIL load_use.bubble_sel got=%0d exp=0", fwd1_sel); end
    idle(1);
    n_cmp++; if (fwd1_sel !== 2'd2) begin n_err++; $display("FAIL load_use.fwd1 got=%0d exp=2", fwd1_sel); end
  endtask

  task automatic test_branch();
    idle(2);
    put(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL branch.flush0 got=%0b exp=1", flush); end
    n_cmp++; if (issue !== 1'b0) begin n_err++; $display("FAIL branch.issue0 got=%0b exp=0", issue); end
    put(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL branch.flush1 got=%0b exp=1", flush); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL branch.stall1 got=%0b exp=1", stall); end
    n_cmp++; if (issue !== 1'b0) begin n_err++; $display("FAIL branch.issue1 got=%0b exp=0", issue); end
    idle(1);
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL branch.flush_end got=%0b exp=0", flush); end
    idle(3);
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL branch.halt_squashed got=%0b exp=0", halted); end
  endtask

  task automatic test_halt();
    idle(2);
    put(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    put(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    put(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL halt.issue got=%0b exp=1", issue); end
    idle(1);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL halt.stall got=%0b exp=1", stall); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt.early1 got=%0b exp=0", halted); end
    idle(1);
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt.early2 got=%0b exp=0", halted); end
    idle(1);
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt.halted got=%0b exp=1", halted); end
    put(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    idle(2);
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt.held got=%0b exp=1", halted); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL halt.stall_held got=%0b exp=1", stall); end
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt.rst_halted got=%0b exp=0", halted); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL halt.rst_stall got=%0b exp=0", stall); end
    put(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL halt.rst_run got=%0b exp=1", issue); end
  endtask

  task automatic test_async_reset();
    idle(2);
    put(1, 0, 0, 0, 0, 4, 1, 0, 0, 1);
    idle(1);
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL async.flush_before got=%0b exp=1", flush); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL async.flush_drop got=%0b exp=0", flush); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL async.stall got=%0b exp=0", stall); end
    #1 rst = 1'b0;
    put(1, 4, 1, 0, 0, 5, 1, 0, 0, 0);
    n_cmp++; if (issue !== 1'b1) begin n_err++; $display("FAIL async.run got=%0b exp=1", issue); end
    idle(1);
    n_cmp++; if (fwd1_sel !== 2'd0) begin n_err++; $display("FAIL async.slots_clear got=%0d exp=0", fwd1_sel); end
  endtask

  // Reference model: history of what entered EX each cycle, plus the cycle
  // of the last accepted branch and of the issued halt.
  typedef struct packed {
    logic       v;
    logic [3:0] d;
    logic       w;
    logic       l;
  } rec_t;

  function automatic bit hits(input rec_t r, input logic [3:0] s, input logic u);
    return r.v && r.w && (r.d == s) && u;
  endfunction

  task automatic test_random();
    rec_t hist[$];
    rec_t ex, mem, cur;
    int t, lb, h;
    logic [1:0] efwd1, efwd2, s1e, s2e;
    bit draining, flush_state, br_acc, lu, e_issue, e_stall, e_flush, e_halted;
    logic v, u1, u2, w, l, hl, b;
    logic [3:0] s1, s2, d;

    do_reset();
    hist = {rec_t'(0), rec_t'(0)};
    t = 0; lb = -100; h = -1; efwd1 = 0; efwd2 = 0;
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(0, 9) < 8);
      s1 = 4'($urandom_range(0, 3)); u1 = ($urandom_range(0, 3) != 0);
      s2 = 4'($urandom_range(0, 3)); u2 = ($urandom_range(0, 3) != 0);
      d  = 4'($urandom_range(0, 3)); w  = ($urandom_range(0, 9) < 7);
      l  = ($urandom_range(0, 9) < 3);
      hl = ($urandom_range(0, 39) == 0);
      b  = ($urandom_range(0, 11) == 0);
      put(v, s1, u1, s2, u2, d, w, l, hl, b);

      ex  = hist[hist.size()-1];
      mem = hist[hist.size()-2];
      draining    = (h >= 0);
      e_halted    = (h >= 0) && (t >= h + 3);
      flush_state = (t > lb) && (t <= lb + FC - 1);
      br_acc      = b && !draining;
      lu          = v && ex.l && (hits(ex, s1, u1) || hits(ex, s2, u2));
      e_issue     = !draining && !flush_state && !br_acc && v && !lu;
      e_stall     = draining || flush_state || (v && lu);
      e_flush     = br_acc || flush_state;
      s1e = (hits(ex, s1, u1) && !ex.l) ? 2'd1 : (hits(mem, s1, u1) ? 2'd2 : 2'd0);
      s2e = (hits(ex, s2, u2) && !ex.l) ? 2'd1 : (hits(mem, s2, u2) ? 2'd2 : 2'd0);

      n_cmp++; if (issue !== e_issue) begin n_err++; $display("FAIL rand.issue n=%0d got=%0b exp=%0b", n, issue, e_issue); end
      n_cmp++; if (stall !== e_stall) begin n_err++; $display("FAIL rand.stall n=%0d got=%0b exp=%0b", n, stall, e_stall); end
      n_cmp++; if (flush !== e_flush) begin n_err++; $display("FAIL rand.flush n=%0d got=%0b exp=%0b", n, flush, e_flush); end
      n_cmp++; if (halted !== e_halted) begin n_err++; $display("FAIL rand.halted n=%0d got=%0b exp=%0b", n, halted, e_halted); end
      n_cmp++; if (fwd1_sel !== efwd1) begin n_err++; $display("FAIL rand.fwd1 n=%0d got=%0d exp=%0d", n, fwd1_sel, efwd1); end
      n_cmp++; if (fwd2_sel !== efwd2) begin n_err++; $display("FAIL rand.fwd2 n=%0d got=%0d exp=%0d", n, fwd2_sel, efwd2); end

      cur = e_issue ? rec_t'{v: 1'b1, d: d, w: w, l: l} : rec_t'(0);
      hist.push_back(cur);
      void'(hist.pop_front());
      efwd1 = e_issue ? s1e : 2'd0;
      efwd2 = e_issue ? s2e : 2'd0;
      if (br_acc) lb = t;
      if (e_issue && hl) h = t;
      t++;

      if (e_halted && (t >= h + 6)) begin
        do_reset();
        hist = {rec_t'(0), rec_t'(0)};
        t = 0; lb = -100; h = -1; efwd1 = 0; efwd2 = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_branch();
    test_halt();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
